// File: rtl/spi_slave_burst.sv
// spi_slave_burst: SPI slave front-end for the single-port RAM subsystem.
// Deserialises {cmd, payload} frames onto rx_data/rx_valid, and serialises
// RAM read data from tx_data/tx_valid onto MISO. With BURST=1 a frame can
// carry several words while SS_n stays low.
// Optional: define SPI_ERR_CNT_EN to add the err_cnt aborted-frame counter.
module spi_slave_burst #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter bit BURST  = 1'b1,
    localparam int PW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          SS_n,
    input  logic          MOSI,
    output logic          MISO,
    output logic [PW+1:0] rx_data,
    output logic          rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic          tx_valid
`ifdef SPI_ERR_CNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    localparam int CW = $clog2(PW + 2);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                cmd1_q, cmd1_d;
    logic                cmd0_q, cmd0_d;
    logic [PW-1:0]       pay_q, pay_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;
    logic [PW+1:0]       rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                miso_q, miso_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic                abort;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cmd1_q         <= 1'b0;
            cmd0_q         <= 1'b0;
            pay_q          <= '0;
            wr_done_q      <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            tx_sr_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd1_q         <= cmd1_d;
            cmd0_q         <= cmd0_d;
            pay_q          <= pay_d;
            wr_done_q      <= wr_done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            tx_sr_q        <= tx_sr_d;
        end
    end

    // Next-state and datapath logic. wr_done_q marks the cycle after a
    // completed WRITE word, where SS_n decides between burst continuation
    // and normal frame end; SHIFT_OUT uses cnt==DATA_W for the same purpose.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd1_d         = cmd1_q;
        cmd0_d         = cmd0_q;
        pay_d          = pay_q;
        wr_done_d      = wr_done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        tx_sr_d        = tx_sr_q;
        abort          = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                wr_done_d = 1'b0;
                miso_d    = 1'b0;
                if (!SS_n) state_d = CHK_CMD;
            end

            CHK_CMD: begin
                if (SS_n) begin
                    abort = 1'b1;
                end else begin
                    cmd1_d = MOSI;
                    cnt_d  = '0;
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
            end

            WRITE, READ_ADD, READ_DATA: begin
                if (wr_done_q) begin
                    // only reachable in WRITE
                    if (SS_n) begin
                        wr_done_d = 1'b0;
                        state_d   = IDLE;
                    end else if (BURST) begin
                        // continuation word: payload only, cmd kept
                        wr_done_d = 1'b0;
                        cnt_d     = CW'(1);
                    end
                end else if (SS_n) begin
                    abort = 1'b1;
                end else begin
                    if (cnt_q == '0) cmd0_d = MOSI;
                    else             pay_d  = {pay_q[PW-2:0], MOSI};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(PW)) begin
                        rx_data_d  = {cmd1_q, cmd0_q, pay_q[PW-2:0], MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        case (state_q)
                            WRITE:    wr_done_d = 1'b1;
                            READ_ADD: begin
                                rd_addr_seen_d = 1'b1;
                                state_d        = IDLE;
                            end
                            default: begin
                                rd_addr_seen_d = 1'b0;
                                state_d        = WAIT_TX;
                            end
                        endcase
                    end
                end
            end

            WAIT_TX: begin
                miso_d = 1'b0;
                if (SS_n) begin
                    abort = 1'b1;
                end else if (tx_valid) begin
                    tx_sr_d = tx_data;
                    cnt_d   = '0;
                    state_d = SHIFT_OUT;
                end
            end

            SHIFT_OUT: begin
                if (cnt_q == CW'(DATA_W)) begin
                    // last bit has been on MISO for a full cycle
                    miso_d = 1'b0;
                    cnt_d  = '0;
                    if (BURST && !SS_n) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {2'b11, {PW{1'b0}}};
                        state_d    = WAIT_TX;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (SS_n) begin
                    abort = 1'b1;
                end else begin
                    miso_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // rd_addr_seen is deliberately left alone on abort
        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            miso_d    = 1'b0;
            wr_done_d = 1'b0;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of frames cut short by SS_n
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (abort && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_burst.sv
// tb_spi_slave_burst: directed bench for spi_slave_burst (ADDR_W=DATA_W=8,
// BURST=1). Inputs change on the falling edge, outputs are checked on the
// falling edge, half a cycle after the DUT's rising edge.
module tb_spi_slave_burst;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;

    spi_slave_burst #(.ADDR_W(8), .DATA_W(8), .BURST(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // count every rx_valid cycle seen by the DUT's own clock
    always @(posedge clk) if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // shift n bits of v, MSB first, one per clock
    task automatic drive_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = v[i];
            @(negedge clk);
        end
    endtask

    // SS_n low, then a full 10-bit {cmd, payload}; ends right after the last bit edge
    task automatic frame(input logic [9:0] v);
        SS_n = 1'b0;
        @(negedge clk);
        drive_bits({6'd0, v}, 10);
    endtask

    logic [7:0] exp_byte;

    initial begin
        rst_n = 1'b0; SS_n = 1'b0; MOSI = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;

        // reset held with SS_n low
        repeat (5) @(negedge clk);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_rxv", rx_valid, 1'b0);
        chk("rst_rxdata", rx_data, 10'h000);
        SS_n = 1'b1; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_cnt", rxv_cnt, 0);
`ifdef SPI_ERR_CNT_EN
        chk("rst_err", err_cnt, 8'd0);
`endif

        // single write-address frame
        frame({2'b00, 8'hA5});
        chk("wr_rxv", rx_valid, 1'b1);
        chk("wr_rxdata", rx_data, 10'h0A5);
        SS_n = 1'b1;
        @(negedge clk);
        chk("wr_rxv_pulse", rx_valid, 1'b0);
        @(negedge clk);

        // read address then read data with MISO serialisation
        frame({2'b10, 8'h3C});
        chk("ra_rxv", rx_valid, 1'b1);
        chk("ra_rxdata", rx_data, 10'h23C);
        SS_n = 1'b1;
        @(negedge clk);
        frame({2'b11, 8'h00});
        chk("rd_rxv", rx_valid, 1'b1);
        chk("rd_rxdata", rx_data, 10'h300);
        @(negedge clk);
        chk("rd_wait_miso", MISO, 1'b0);
        tx_valid = 1'b1; tx_data = 8'h96;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00;
        exp_byte = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            chk($sformatf("rd_miso_b%0d", i), MISO, exp_byte[i]);
        end
        SS_n = 1'b1;
        @(negedge clk);
        chk("rd_end_miso", MISO, 1'b0);
        chk("rd_end_rxv", rx_valid, 1'b0);

        // burst write: three words spaced 9 cycles
        frame({2'b01, 8'h11});
        chk("bw0_rxv", rx_valid, 1'b1);
        chk("bw0_rxdata", rx_data, 10'h111);
        @(negedge clk);
        chk("bw_gap_rxv", rx_valid, 1'b0);
        drive_bits(16'h0022, 8);
        chk("bw1_rxv", rx_valid, 1'b1);
        chk("bw1_rxdata", rx_data, 10'h122);
        @(negedge clk);
        drive_bits(16'h0033, 8);
        chk("bw2_rxv", rx_valid, 1'b1);
        chk("bw2_rxdata", rx_data, 10'h133);
        SS_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bw_pulses", rxv_cnt, 6);

        // abort after 5 payload bits
        SS_n = 1'b0;
        @(negedge clk);
        drive_bits({9'd0, 2'b00, 5'b10110}, 7);
        SS_n = 1'b1;
        @(negedge clk);
        chk("ab_rxv", rx_valid, 1'b0);
        @(negedge clk);
        chk("ab_rxv2", rx_valid, 1'b0);
        chk("ab_pulses", rxv_cnt, 6);
`ifdef SPI_ERR_CNT_EN
        chk("ab_err", err_cnt, 8'd1);
`endif
        frame({2'b00, 8'h5A});
        chk("ab_next_rxv", rx_valid, 1'b1);
        chk("ab_next_rxdata", rx_data, 10'h05A);
        SS_n = 1'b1;
        @(negedge clk);

        // cmd 11 with no address seen behaves as read-address
        frame({2'b11, 8'h77});
        chk("rd0_rxv", rx_valid, 1'b1);
        chk("rd0_rxdata", rx_data, 10'h377);
        SS_n = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rd0_miso%0d", i), MISO, 1'b0);
        end
        tx_valid = 1'b0; tx_data = 8'h00;

        // address now seen: read data, then abort while waiting for tx_valid
        frame({2'b11, 8'h00});
        chk("rdw_rxdata", rx_data, 10'h300);
        @(negedge clk);
        chk("rdw_miso", MISO, 1'b0);
        SS_n = 1'b1;
        @(negedge clk);
        chk("rdw_ab_miso", MISO, 1'b0);
        chk("rdw_ab_rxv", rx_valid, 1'b0);
`ifdef SPI_ERR_CNT_EN
        chk("rdw_ab_err", err_cnt, 8'd2);
`endif
        @(negedge clk);
        chk("total_pulses", rxv_cnt, 9);

        // asynchronous reset while rx_valid is high
        frame({2'b01, 8'h0C});
        chk("ar_rxdata", rx_data, 10'h10C);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rxv", rx_valid, 1'b0);
        chk("ar_rxdata0", rx_data, 10'h000);
        chk("ar_miso", MISO, 1'b0);
`ifdef SPI_ERR_CNT_EN
        chk("ar_err", err_cnt, 8'd0);
`endif
        @(negedge clk);
        SS_n = 1'b1; rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
- Parametrised next-generation SPI slave front-end for the single-port RAM subsystem.
- Generalises frame widths via ADDR_W and DATA_W.
- Adds multi-word burst write and burst read while SS_n stays low.
- Sits between the SPI pins and the RAM; carries command+payload words to the RAM on rx_data/rx_valid and returns read data on tx_data/tx_valid.

Parameters:
- ADDR_W, 8, address payload width (bits)
- DATA_W, 8, data word width (bits)
- BURST, 1, 1 = burst continuation allowed while SS_n low; 0 = one word per frame

Ports:
- clk  in  1  SPI/system clock; all sampling on rising edge
- rst_n  in  1  reset: asynchronous, active-low
- SS_n  in  1  slave select, active-low
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first
- rx_data  out  PW+2  {cmd[1:0], payload}; PW = max(ADDR_W, DATA_W)
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  DATA_W  read data from RAM
- tx_valid  in  1  tx_data valid (sampled only in WAIT_TX)
- err_cnt  out  8  aborted-frame count; present only with SPI_ERR_CNT_EN

Behaviour:
- Reset: state=IDLE; MISO=0, rx_data=0, rx_valid=0, rd_addr_seen=0, shift count=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT.
- IDLE → CHK_CMD on the edge where SS_n=0. No bit is consumed in this transition.
- CHK_CMD samples MOSI as cmd[1] and stores it. Next state:
  - cmd[1]=0 → WRITE
  - cmd[1]=1 and rd_addr_seen=0 → READ_ADD
  - cmd[1]=1 and rd_addr_seen=1 → READ_DATA
- WRITE/READ_ADD/READ_DATA shift in 1+PW bits: cmd[0], then payload MSB first.
  - After the last bit, rx_data is updated and rx_valid=1 on the next cycle, for exactly one cycle.
  - PW=8 timing: SS_n low at edge E0 → rx_valid high after E10.
- rx_data carries the bits as received. State selection uses only cmd[1] and rd_addr_seen.
- READ_ADD completion sets rd_addr_seen. READ_DATA rx_valid clears rd_addr_seen.
- WRITE completion:
  - BURST=1 and SS_n still low: stay in WRITE and shift the next PW bits. Each completed word gives rx_valid with the cmd of the first word.
  - Otherwise go to IDLE when SS_n is high.
- READ_DATA completion → WAIT_TX. WAIT_TX holds, MISO=0, until tx_valid=1 is sampled.
  - tx_data is latched on that edge → SHIFT_OUT.
- SHIFT_OUT: MISO = latched bit DATA_W-1 from the next edge, shifting one bit per edge. DATA_W edges in total.
  - Last bit sent, BURST=1 and SS_n low: rx_valid pulses with rx_data={2'b11, 0}, then WAIT_TX (next-word request).
  - Otherwise → IDLE; MISO returns to 0.
- Abort: SS_n=1 sampled in any non-IDLE state:
  - next state IDLE, shift count cleared, no rx_valid, MISO=0
  - rd_addr_seen unchanged
- tx_valid outside WAIT_TX is ignored.
- Reset mid-frame: immediate return to reset values, independent of clk.
- Widths: shift counter sized $clog2(PW+2). DATA_W > PW is illegal, which cannot occur because PW ≥ DATA_W.

Optional Feature:
- Macro SPI_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 on each abort from CHK_CMD/WRITE/READ_ADD/READ_DATA/WAIT_TX/SHIFT_OUT.
  - Excludes the normal frame end: WRITE after a complete word, SHIFT_OUT after its last bit.
  - Saturates at 255; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with SS_n=0 for 5 cycles, then release → MISO=0, rx_valid=0, no rx_valid until a full frame arrives.
- Write-address frame, cmd 00, payload 8'hA5, then SS_n=1 → single rx_valid with rx_data=10'h0A5, 11 edges after SS_n fall; state IDLE afterwards.
- Read-address 8'h3C, then a read-data frame, cmd 11, with tx_valid=1 and tx_data=8'h96 two cycles after rx_valid:
  - rx_data=10'h23C on the first frame, then 10'h300
  - MISO=1,0,0,1,0,1,1,0 on 8 consecutive edges
- BURST=1 write, cmd 01, payloads 8'h11, 8'h22, 8'h33 with SS_n held low → three rx_valid pulses, rx_data=10'h111, 10'h122, 10'h133, spaced 9 cycles apart.
- Abort: SS_n raised after 5 payload bits of a write → no rx_valid, IDLE next edge; err_cnt=1 with SPI_ERR_CNT_EN. The next full frame completes normally.
- Read-data frame with rd_addr_seen=0 → treated as READ_ADD, rx_valid with cmd 11 as received; MISO stays 0 and no WAIT_TX entry.
